// File: rtl/rv32iv_pkg.sv
// Shared RV32IV core definitions: hazard-unit FSM states and common constants.
package rv32iv_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    VEC_BUSY = 1'b1
  } hsu_state_t;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         VEC_LAT_DEFAULT = 4;
  localparam int         STAT_W_DEFAULT  = 16;

endpackage : rv32iv_pkg

// File: rtl/hazard_stall_unit_if.sv
// ID-stage hazard bus: register/flag inputs from the pipeline and the
// stall/flush controls plus the stall counter back to it.
interface hazard_stall_unit_if #(
  parameter int STAT_W = 16
);

  logic [4:0]        IFID_Rs1_i;
  logic [4:0]        IFID_Rs2_i;
  logic [4:0]        IDEX_Rd_i;
  logic              IDEX_MemRead_i;
  logic              IDEX_VecOp_i;
  logic              Branch_Taken_i;
  logic              Hazard_o;
  logic              PCWrite_o;
  logic              IFIDWrite_o;
  logic              IDEXWrite_o;
  logic              IFIDFlush_o;
  logic [STAT_W-1:0] StallCnt_o;

  // Pipeline side: supplies the ID/EX fields, consumes the controls.
  modport master (
    output IFID_Rs1_i, IFID_Rs2_i, IDEX_Rd_i, IDEX_MemRead_i,
           IDEX_VecOp_i, Branch_Taken_i,
    input  Hazard_o, PCWrite_o, IFIDWrite_o, IDEXWrite_o, IFIDFlush_o,
           StallCnt_o
  );

  // Hazard unit side.
  modport slave (
    input  IFID_Rs1_i, IFID_Rs2_i, IDEX_Rd_i, IDEX_MemRead_i,
           IDEX_VecOp_i, Branch_Taken_i,
    output Hazard_o, PCWrite_o, IFIDWrite_o, IDEXWrite_o, IFIDFlush_o,
           StallCnt_o
  );

endinterface : hazard_stall_unit_if

// File: rtl/sat_counter.sv
// Generic saturating up-counter with increment enable and synchronous
// active-low clear; intended for performance counters.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             clr_n_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  // Count up on enable, stick at all-ones; clear has priority.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule : sat_counter

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard controller: load-use bubbles, front-end freeze while a
// multi-cycle vector op sits in EX, IF/ID squash on taken branches, and a
// saturating stall-cycle counter.
module hazard_stall_unit
  import rv32iv_pkg::*;
#(
  parameter int VEC_LAT = VEC_LAT_DEFAULT,
  parameter int STAT_W  = STAT_W_DEFAULT
) (
  input logic                clk_i,
  input logic                rst_n_i,
  hazard_stall_unit_if.slave bus
);

  // Hold counter needs to reach VEC_LAT-2; keep at least one bit.
  localparam int  CNT_W     = (VEC_LAT > 2) ? $clog2(VEC_LAT) : 1;
  localparam bit  VEC_HOLDS = (VEC_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_INIT = VEC_HOLDS ? CNT_W'(VEC_LAT - 2) : '0;

  hsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_use;
  logic vec_trig;
  logic hold_cycle;
  logic branch;
  logic hazard, pc_write, ifid_write, idex_write, ifid_flush;

  assign branch   = bus.Branch_Taken_i;
  assign vec_trig = VEC_HOLDS && bus.IDEX_VecOp_i;
  assign load_use = bus.IDEX_MemRead_i && (bus.IDEX_Rd_i != REG_ZERO) &&
                    ((bus.IDEX_Rd_i == bus.IFID_Rs1_i) ||
                     (bus.IDEX_Rd_i == bus.IFID_Rs2_i));
  // Busy with cycles still to go; the cnt==0 busy cycle is the release.
  assign hold_cycle = (state_q == VEC_BUSY) && (cnt_q != '0);

  // State and hold-counter registers; reset also abandons a pending hold.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: enter VEC_BUSY on an unpreempted trigger, count down, release.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (!branch && vec_trig) begin
          state_d = VEC_BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      VEC_BUSY: begin
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: reset force, then hold, then branch > vector trigger > load-use.
  always_comb begin
    hazard     = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    idex_write = 1'b1;
    ifid_flush = 1'b0;
    if (!rst_n_i) begin
      hazard     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
      ifid_flush = 1'b1;
    end else if (hold_cycle) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
    end else if (branch) begin
      hazard     = 1'b1;
      ifid_flush = 1'b1;
    end else if ((state_q == RUN) && vec_trig) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
    end else if (load_use) begin
      hazard     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end
  end

  assign bus.Hazard_o    = hazard;
  assign bus.PCWrite_o   = pc_write;
  assign bus.IFIDWrite_o = ifid_write;
  assign bus.IDEXWrite_o = idex_write;
  assign bus.IFIDFlush_o = ifid_flush;

  // Stall cycles are exactly the cycles with the PC frozen.
  sat_counter #(
    .WIDTH(STAT_W)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .clr_n_i(rst_n_i),
    .inc_i  (!pc_write),
    .count_o(bus.StallCnt_o)
  );

  // EX holds a vector op during hold cycles, so a taken branch is impossible.
  a_no_branch_in_hold : assert property (
    @(posedge clk_i) disable iff (!rst_n_i) !(hold_cycle && branch)
  );

endmodule : hazard_stall_unit

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: three instances (VEC_LAT=4/STAT_W=16,
// VEC_LAT=1/STAT_W=16, VEC_LAT=4/STAT_W=4) driven by the same stimulus.
module tb_hazard_stall_unit;

  // {Hazard, PCWrite, IFIDWrite, IDEXWrite, IFIDFlush}
  localparam logic [4:0] O_DEF  = 5'b01110;
  localparam logic [4:0] O_LU   = 5'b10010;
  localparam logic [4:0] O_HOLD = 5'b00000;
  localparam logic [4:0] O_BR   = 5'b11111;
  localparam logic [4:0] O_RST  = 5'b10001;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hazard_stall_unit_if #(.STAT_W(16)) if_v4 ();
  hazard_stall_unit_if #(.STAT_W(16)) if_v1 ();
  hazard_stall_unit_if #(.STAT_W(4))  if_s4 ();

  hazard_stall_unit #(.VEC_LAT(4), .STAT_W(16)) u_v4 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(if_v4));
  hazard_stall_unit #(.VEC_LAT(1), .STAT_W(16)) u_v1 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(if_v1));
  hazard_stall_unit #(.VEC_LAT(4), .STAT_W(4))  u_s4 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(if_s4));

  logic [4:0] o_v4, o_v1, o_s4;
  assign o_v4 = {if_v4.Hazard_o, if_v4.PCWrite_o, if_v4.IFIDWrite_o,
                 if_v4.IDEXWrite_o, if_v4.IFIDFlush_o};
  assign o_v1 = {if_v1.Hazard_o, if_v1.PCWrite_o, if_v1.IFIDWrite_o,
                 if_v1.IDEXWrite_o, if_v1.IFIDFlush_o};
  assign o_s4 = {if_s4.Hazard_o, if_s4.PCWrite_o, if_s4.IFIDWrite_o,
                 if_s4.IDEXWrite_o, if_s4.IFIDFlush_o};

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the same ID/EX fields to all three instances.
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic mr,
                       input logic vo, input logic br);
    if_v4.IFID_Rs1_i = rs1; if_v4.IFID_Rs2_i = rs2; if_v4.IDEX_Rd_i = rd;
    if_v4.IDEX_MemRead_i = mr; if_v4.IDEX_VecOp_i = vo; if_v4.Branch_Taken_i = br;
    if_v1.IFID_Rs1_i = rs1; if_v1.IFID_Rs2_i = rs2; if_v1.IDEX_Rd_i = rd;
    if_v1.IDEX_MemRead_i = mr; if_v1.IDEX_VecOp_i = vo; if_v1.Branch_Taken_i = br;
    if_s4.IFID_Rs1_i = rs1; if_s4.IFID_Rs2_i = rs2; if_s4.IDEX_Rd_i = rd;
    if_s4.IDEX_MemRead_i = mr; if_s4.IDEX_VecOp_i = vo; if_s4.Branch_Taken_i = br;
  endtask

  // Each step: drive at the falling edge, sample 1 time unit later.
  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic mr,
                      input logic vo, input logic br);
    @(negedge clk);
    drive(rs1, rs2, rd, mr, vo, br);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Reset: forced outputs while low.
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("rst_out_v4", 32'(o_v4), 32'(O_RST));
    check("rst_out_v1", 32'(o_v1), 32'(O_RST));
    check("rst_out_s4", 32'(o_s4), 32'(O_RST));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_out_v4", 32'(o_v4), 32'(O_DEF));
    check("post_rst_out_s4", 32'(o_s4), 32'(O_DEF));
    check("post_rst_cnt_v4", 32'(if_v4.StallCnt_o), 32'd0);
    check("post_rst_cnt_s4", 32'(if_s4.StallCnt_o), 32'd0);

    // Load-use on rs2.
    step(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
    check("lu_rs2_v4", 32'(o_v4), 32'(O_LU));
    check("lu_rs2_v1", 32'(o_v1), 32'(O_LU));
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("lu_after_out", 32'(o_v4), 32'(O_DEF));
    check("lu_after_cnt_v4", 32'(if_v4.StallCnt_o), 32'd1);
    check("lu_after_cnt_s4", 32'(if_s4.StallCnt_o), 32'd1);

    // Load with rd=x0 never stalls.
    step(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("lu_x0_out", 32'(o_v4), 32'(O_DEF));
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("lu_x0_cnt", 32'(if_v4.StallCnt_o), 32'd1);

    // Vector hold: VEC_LAT=4 holds 3 cycles, VEC_LAT=1 never holds.
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("vec_c1_v4", 32'(o_v4), 32'(O_HOLD));
    check("vec_c1_v1", 32'(o_v1), 32'(O_DEF));
    check("vec_c1_s4", 32'(o_s4), 32'(O_HOLD));
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("vec_c2_v4", 32'(o_v4), 32'(O_HOLD));
    check("vec_c2_cnt", 32'(if_v4.StallCnt_o), 32'd2);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("vec_c3_v4", 32'(o_v4), 32'(O_HOLD));
    check("vec_c3_cnt", 32'(if_v4.StallCnt_o), 32'd3);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("vec_rel_v4", 32'(o_v4), 32'(O_DEF));
    check("vec_rel_v1", 32'(o_v1), 32'(O_DEF));
    check("vec_rel_cnt_v4", 32'(if_v4.StallCnt_o), 32'd4);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("vec_done_out", 32'(o_v4), 32'(O_DEF));
    check("vec_done_cnt_v4", 32'(if_v4.StallCnt_o), 32'd4);
    check("vec_done_cnt_v1", 32'(if_v1.StallCnt_o), 32'd1);

    // Branch beats load-use; no stall counted.
    step(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
    check("br_lu_v4", 32'(o_v4), 32'(O_BR));
    check("br_lu_v1", 32'(o_v1), 32'(O_BR));
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("br_cnt_v4", 32'(if_v4.StallCnt_o), 32'd4);
    check("br_cnt_v1", 32'(if_v1.StallCnt_o), 32'd1);

    // Load-use presented on the release cycle.
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("rel_c1", 32'(o_v4), 32'(O_HOLD));
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("rel_c2", 32'(o_v4), 32'(O_HOLD));
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("rel_c3", 32'(o_v4), 32'(O_HOLD));
    step(5'd7, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
    check("rel_lu_v4", 32'(o_v4), 32'(O_LU));
    check("rel_lu_v1", 32'(o_v1), 32'(O_LU));
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("rel_next_out", 32'(o_v4), 32'(O_DEF));
    check("rel_next_cnt_v4", 32'(if_v4.StallCnt_o), 32'd8);
    check("rel_next_cnt_v1", 32'(if_v1.StallCnt_o), 32'd2);
    check("rel_next_cnt_s4", 32'(if_s4.StallCnt_o), 32'd8);

    // Reset at hold cycle 2.
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("mid_c1", 32'(o_v4), 32'(O_HOLD));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", 32'(o_v4), 32'(O_RST));
    check("mid_rst_cnt", 32'(if_v4.StallCnt_o), 32'd9);
    @(negedge clk);
    rst_n = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("mid_after_out", 32'(o_v4), 32'(O_DEF));
    check("mid_after_cnt_v4", 32'(if_v4.StallCnt_o), 32'd0);
    check("mid_after_cnt_v1", 32'(if_v1.StallCnt_o), 32'd0);

    // Saturation: 20 stall cycles on the 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      step(5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
      if (i == 0) check("sat_lu_out", 32'(o_s4), 32'(O_LU));
      check($sformatf("sat_cnt_%0d", i), 32'(if_s4.StallCnt_o),
            (i < 15) ? 32'(i) : 32'd15);
    end
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("sat_final_s4", 32'(if_s4.StallCnt_o), 32'd15);
    check("sat_final_v4", 32'(if_v4.StallCnt_o), 32'd20);
    check("sat_final_v1", 32'(if_v1.StallCnt_o), 32'd20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_hazard_stall_unit

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard controller in the ID stage of the RV32IV core. Detects load-use hazards, freezes the front end while a multi-cycle vector op occupies EX, and squashes the ID instruction on a taken branch. `Hazard_o` feeds the ID-stage control-bubble mux. The PC, IF/ID and ID/EX write enables and the IF/ID flush come from here. A saturating stall counter gives performance visibility.

## Interface
- `VEC_LAT`, 4: cycles a vector op occupies EX; must be ≥1.
- `STAT_W`, 16: width of the stall-cycle counter.
- `clk_i` in 1: core clock.
- `rst_n_i` in 1: synchronous, active-low reset.
- `IFID_Rs1_i` in 5: rs1 of the instruction in ID.
- `IFID_Rs2_i` in 5: rs2 of the instruction in ID.
- `IDEX_Rd_i` in 5: rd of the instruction in EX.
- `IDEX_MemRead_i` in 1: the EX instruction is a load.
- `IDEX_VecOp_i` in 1: the EX instruction is a vector op.
- `Branch_Taken_i` in 1: a branch in EX resolved as taken this cycle.
- `Hazard_o` out 1: zero ID control signals, i.e. insert a bubble into ID/EX.
- `PCWrite_o` out 1: PC update enable.
- `IFIDWrite_o` out 1: IF/ID register write enable.
- `IDEXWrite_o` out 1: ID/EX register write enable (0 holds EX contents).
- `IFIDFlush_o` out 1: clear IF/ID to a NOP.
- `StallCnt_o` out STAT_W: saturating count of cycles with `PCWrite_o`=0.

## Operation
- **States:** RUN, VEC_BUSY. There is a down-counter `cnt` of width `$clog2(VEC_LAT)` (min 1).
- **Defaults:** `Hazard_o`=0, `PCWrite_o`=1, `IFIDWrite_o`=1, `IDEXWrite_o`=1, `IFIDFlush_o`=0.
- **Priority in RUN and in the VEC_BUSY release cycle:** branch > vector trigger > load-use.
  - **Branch:** when `Branch_Taken_i`=1, assert `IFIDFlush_o`=1 and `Hazard_o`=1. The PC and IF/ID write enables stay 1. No other hazard is evaluated.
  - **Vector trigger:** applies in RUN only, when `IDEX_VecOp_i`=1 and `VEC_LAT`>1.
    - Assert `PCWrite_o`=`IFIDWrite_o`=`IDEXWrite_o`=0 and `Hazard_o`=0 (a hold, not a bubble).
    - Next state is VEC_BUSY with `cnt`=`VEC_LAT`-2.
  - **Load-use:** when `IDEX_MemRead_i`=1, `IDEX_Rd_i`≠0 and (`IDEX_Rd_i`==`IFID_Rs1_i` or `IDEX_Rd_i`==`IFID_Rs2_i`), assert `Hazard_o`=1 and `PCWrite_o`=`IFIDWrite_o`=0. `IDEXWrite_o` stays 1 so the bubble is written.
- **VEC_BUSY with `cnt`≠0:** full hold, same as the trigger cycle; `cnt` decrements.
- **VEC_BUSY with `cnt`==0 (release cycle):** the op leaves EX, RUN priority rules apply except the vector trigger, and next state is RUN. This makes the hold last exactly `VEC_LAT`-1 cycles and guarantees no re-trigger on the same op.
- **`VEC_LAT`==1:** a vector op never holds and VEC_BUSY is unreachable.
- **`Branch_Taken_i` during hold cycles:** cannot occur (EX holds a vector op). If it does occur, it is ignored and flagged by an assertion.
- **`StallCnt_o`:** +1 on every cycle with `PCWrite_o`=0, saturating at all-ones.
- **Reset:** while `rst_n_i`=0 at the clock edge, the next state is RUN, `cnt`=0 and `StallCnt_o`=0.
  - During any cycle in which `rst_n_i` is low, outputs are forced to `Hazard_o`=1, `PCWrite_o`=`IFIDWrite_o`=`IDEXWrite_o`=0 and `IFIDFlush_o`=1.
  - Reset mid-hold abandons VEC_BUSY.
- **Values after reset:** state RUN, all defaults, `StallCnt_o`=0.

## Timing
- Hazard outputs are combinational from the inputs and the registered state, with zero-cycle latency in the detection cycle. State, `cnt` and `StallCnt_o` are registered.
- A load-use stall lasts exactly 1 cycle. The next cycle sees a bubble in EX (`IDEX_MemRead_i`=0), so no repeat.
- A vector op stays in EX for `VEC_LAT` cycles; the front end is frozen for `VEC_LAT`-1 cycles.
- A branch flush lasts 1 cycle and injects no extra stall.
- `StallCnt_o` reflects a stall cycle one clock later.

## Structure
- **Shared package `rv32iv_pkg`:** state enum `hsu_state_t` {RUN, VEC_BUSY}, constant `REG_ZERO`=5'd0, and the `VEC_LAT` default.
- **Sub-module `sat_counter`** (parameterised width, increment enable, sync active-low clear) implements `StallCnt_o`. It is reusable by other performance counters.
- All other logic stays flat.

## Test plan
- **Load-use stall:** `IDEX_MemRead_i`=1, `IDEX_Rd_i`=5, `IFID_Rs2_i`=5 → `Hazard_o`=1, `PCWrite_o`=`IFIDWrite_o`=0 and `IDEXWrite_o`=1 for one cycle; `StallCnt_o`=1 the next cycle. Repeat with `IDEX_Rd_i`=0 → no stall.
- **Vector hold:** `VEC_LAT`=4, `IDEX_VecOp_i` held at 1 → 3 cycles with all write enables 0 and `Hazard_o`=0; 4th cycle releases; `StallCnt_o`=3. Repeat with `VEC_LAT`=1 → no hold.
- **Branch vs load-use:** `Branch_Taken_i`=1 together with a load-use match → `IFIDFlush_o`=1, `Hazard_o`=1, `PCWrite_o`=1; `StallCnt_o` unchanged.
- **Release cycle:** load-use match presented on the VEC_BUSY release cycle → 1-cycle bubble follows immediately, with no vector re-trigger.
- **Reset mid-hold:** `rst_n_i`=0 at hold cycle 2 → forced reset outputs; after release, state is RUN, `StallCnt_o`=0 and default outputs apply.
- **Saturation:** `STAT_W`=4, 20 stall cycles → `StallCnt_o` saturates at 15 and holds.
